// File: rtl/morse_symbol_decoder.sv
// Morse keyer front end: synchronises and debounces an active-low key, classifies
// presses as dot/dash and packs them into a left-aligned 2-bit-per-symbol letter code.
module morse_symbol_decoder #(
  parameter int unsigned MAX_SYMBOLS     = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DASH_CYCLES     = 10,
  parameter int unsigned GAP_CYCLES      = 30,
  parameter int unsigned CNT_W           = 26,
  localparam int unsigned CODE_W         = 2 * MAX_SYMBOLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              key_n,
  output logic              dot,
  output logic              dash,
  output logic [CODE_W-1:0] code,
  output logic [3:0]        symbol_count,
  output logic              code_valid,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  state_e           state_q;
  logic             sync1_q, sync2_q;
  // Key levels keep key_n polarity: 1 = released.
  logic             deb_q, deb_prev_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic             letter_done_q;

  logic              press_edge, release_edge;
  logic [1:0]        sym;
  logic [CODE_W-1:0] base_code, sym_msb, append_code;
  logic [3:0]        base_count, append_count;
  logic              append_ovf;

  // Synchroniser and debouncer; these keep running regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_edge   = deb_prev_q & ~deb_q;
  assign release_edge = ~deb_prev_q & deb_q;
  assign busy         = (state_q != StIdle);

  // Next accumulator contents if a symbol is appended this cycle. press_cnt_q lags the
  // debounced press width by one, hence the DASH_CYCLES-1 threshold.
  always_comb begin
    sym        = (press_cnt_q >= CNT_W'(DASH_CYCLES - 1)) ? 2'b11 : 2'b10;
    base_code  = letter_done_q ? '0 : code;
    base_count = letter_done_q ? 4'd0 : symbol_count;
    append_ovf = letter_done_q ? 1'b0 : overflow;
    sym_msb    = CODE_W'(sym) << (CODE_W - 2);
    if (base_count < 4'(MAX_SYMBOLS)) begin
      append_code  = base_code | (sym_msb >> (2 * base_count));
      append_count = base_count + 4'd1;
    end else begin
      append_code  = (base_code << 2) | CODE_W'(sym);
      append_count = base_count;
      append_ovf   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      press_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      letter_done_q <= 1'b0;
      code          <= '0;
      symbol_count  <= '0;
      overflow      <= 1'b0;
      dot           <= 1'b0;
      dash          <= 1'b0;
      code_valid    <= 1'b0;
    end else begin
      dot        <= 1'b0;
      dash       <= 1'b0;
      code_valid <= 1'b0;
      if (clear) begin
        state_q       <= StIdle;
        code          <= '0;
        symbol_count  <= '0;
        overflow      <= 1'b0;
        letter_done_q <= 1'b0;
      end else if (!enable) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (press_edge) begin
              state_q     <= StPress;
              press_cnt_q <= '0;
            end
          end
          StPress: begin
            if (release_edge) begin
              code          <= append_code;
              symbol_count  <= append_count;
              overflow      <= append_ovf;
              letter_done_q <= 1'b0;
              dot           <= ~sym[0];
              dash          <= sym[0];
              state_q       <= StGap;
              gap_cnt_q     <= '0;
            end else if (press_cnt_q < CNT_W'(DASH_CYCLES)) begin
              press_cnt_q <= press_cnt_q + CNT_W'(1);
            end
          end
          StGap: begin
            // A new press wins over a coincident timeout.
            if (press_edge) begin
              state_q     <= StPress;
              press_cnt_q <= '0;
            end else if (gap_cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
              code_valid    <= 1'b1;
              letter_done_q <= 1'b1;
              state_q       <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Bench for morse_symbol_decoder: timestamp/queue reference model checked every cycle,
// directed letter scenarios with literal expectations, then randomised keying.
module tb_morse_symbol_decoder;

  localparam int DEB  = 2;
  localparam int DASH = 10;
  localparam int GAP  = 30;
  localparam int MAXS = 5;
  localparam int CW   = 2 * MAXS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic          key_n = 1'b1;
  logic          dot, dash, code_valid, overflow, busy;
  logic [CW-1:0] code;
  logic [3:0]    symbol_count;

  morse_symbol_decoder #(
    .MAX_SYMBOLS    (MAXS),
    .DEBOUNCE_CYCLES(DEB),
    .DASH_CYCLES    (DASH),
    .GAP_CYCLES     (GAP),
    .CNT_W          (26)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .key_n       (key_n),
    .dot         (dot),
    .dash        (dash),
    .code        (code),
    .symbol_count(symbol_count),
    .code_valid  (code_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key sample history, run-length debounce, symbol queue per letter.
  localparam int MIdle = 0, MPress = 1, MGap = 2;
  bit key_hist[$];
  bit m_deb, m_deb_d;
  int m_run, m_mode, m_cyc, m_mark;
  bit m_syms[$];
  bit m_done;
  bit e_dot, e_dash, e_valid;

  task automatic model_reset();
    key_hist = '{1'b1, 1'b1};
    m_deb = 1'b1; m_deb_d = 1'b1; m_run = 0;
    m_mode = MIdle; m_syms.delete(); m_done = 1'b0;
    e_dot = 1'b0; e_dash = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_step(input bit k, input bit en, input bit clr);
    bit syn, press_ev, rel_ev, is_dash;
    syn = key_hist[0];
    void'(key_hist.pop_front());
    key_hist.push_back(k);
    press_ev = m_deb_d && !m_deb;
    rel_ev   = !m_deb_d && m_deb;
    m_deb_d = m_deb;
    if (syn != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = syn;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    e_dot = 1'b0; e_dash = 1'b0; e_valid = 1'b0;
    if (clr) begin
      m_mode = MIdle; m_syms.delete(); m_done = 1'b0;
    end else if (!en) begin
      m_mode = MIdle;
    end else if (m_mode == MIdle) begin
      if (press_ev) begin m_mode = MPress; m_mark = m_cyc; end
    end else if (m_mode == MPress) begin
      if (rel_ev) begin
        is_dash = (m_cyc - m_mark) >= DASH;
        if (m_done) m_syms.delete();
        m_done = 1'b0;
        m_syms.push_back(is_dash);
        e_dot = !is_dash; e_dash = is_dash;
        m_mode = MGap; m_mark = m_cyc;
      end
    end else begin
      if (press_ev) begin
        m_mode = MPress; m_mark = m_cyc;
      end else if (m_cyc - m_mark >= GAP) begin
        e_valid = 1'b1; m_done = 1'b1; m_mode = MIdle;
      end
    end
    m_cyc++;
  endtask

  function automatic logic [CW-1:0] exp_code();
    logic [CW-1:0] c = '0;
    int n = m_syms.size();
    int k = (n > MAXS) ? MAXS : n;
    for (int i = 0; i < k; i++) c[CW-1-2*i -: 2] = m_syms[n-k+i] ? 2'b11 : 2'b10;
    return c;
  endfunction

  // Observations of DUT activity used by the directed literal checks.
  int n_dot = 0, n_dash = 0, n_valid = 0;
  bit busy_seen = 1'b0;
  logic [CW-1:0] cap_code[$];
  int cap_cnt[$];
  bit cap_ovf[$];
  logic [CW-1:0] v_code;
  int v_cnt;
  bit v_ovf;

  always @(posedge clk) begin
    bit k, en, clr, rs;
    int n;
    k = key_n; en = enable; clr = clear; rs = reset;
    if (!rs) model_reset();
    else model_step(k, en, clr);
    #1;
    n = m_syms.size();
    chk("dot", dot, e_dot);
    chk("dash", dash, e_dash);
    chk("code_valid", code_valid, e_valid);
    chk("code", code, exp_code());
    chk("symbol_count", symbol_count, (n > MAXS) ? MAXS : n);
    chk("overflow", overflow, n > MAXS);
    chk("busy", busy, m_mode != MIdle);
    if (dot) n_dot++;
    if (dash) n_dash++;
    if (dot || dash) begin
      cap_code.push_back(code); cap_cnt.push_back(symbol_count); cap_ovf.push_back(overflow);
    end
    if (code_valid) begin
      n_valid++; v_code = code; v_cnt = symbol_count; v_ovf = overflow;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic hold(input logic v, input int n);
    key_n = v;
    repeat (n) @(negedge clk);
  endtask

  int d0, s0, v0, seg_left;

  initial begin
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_code", code, 0);
    chk("reset_count", symbol_count, 0);
    chk("reset_pulses", {dot, dash, code_valid, overflow}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Letter A: dot, dash
    hold(1, 40);
    d0 = n_dot; s0 = n_dash; v0 = n_valid;
    hold(0, 4); hold(1, 5); hold(0, 15); hold(1, 40);
    chk("A_dots", n_dot - d0, 1);
    chk("A_dashes", n_dash - s0, 1);
    chk("A_valids", n_valid - v0, 1);
    chk("A_code", v_code, 10'b1011000000);
    chk("A_count", v_cnt, 2);
    chk("A_ovf", v_ovf, 0);

    // Threshold: 9 -> dot, 10 -> dash, new letter clears the old one
    d0 = n_dot; s0 = n_dash;
    hold(0, 9); hold(1, 40);
    chk("thr9_dot", n_dot - d0, 1);
    chk("thr9_dash", n_dash - s0, 0);
    chk("thr9_code", v_code, 10'b1000000000);
    hold(0, 10); hold(1, 8);
    chk("thr10_dash", n_dash - s0, 1);
    chk("thr10_dot", n_dot - d0, 1);
    chk("thr10_code", code, 10'b1100000000);
    chk("thr10_count", symbol_count, 1);
    hold(1, 40);

    // Bounce: single-cycle lows never pass the debouncer
    d0 = n_dot; s0 = n_dash; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hold(0, 1); hold(1, 1);
    end
    hold(1, 20);
    chk("bounce_busy", busy_seen, 0);
    chk("bounce_pulses", (n_dot - d0) + (n_dash - s0), 0);

    // Overflow: five dots then a dash
    cap_code.delete(); cap_cnt.delete(); cap_ovf.delete();
    for (int i = 0; i < 5; i++) begin
      hold(0, 4); hold(1, 5);
    end
    hold(0, 12); hold(1, 40);
    chk("ovf_syms", cap_code.size(), 6);
    if (cap_code.size() == 6) begin
      chk("ovf_5th_code", cap_code[4], 10'b1010101010);
      chk("ovf_5th_count", cap_cnt[4], 5);
      chk("ovf_5th_ovf", cap_ovf[4], 0);
      chk("ovf_6th_code", cap_code[5], 10'b1010101011);
      chk("ovf_6th_count", cap_cnt[5], 5);
      chk("ovf_6th_ovf", cap_ovf[5], 1);
    end
    chk("ovf_valid_code", v_code, 10'b1010101011);
    chk("ovf_valid_ovf", v_ovf, 1);

    // clear in the cycle the release is seen
    d0 = n_dot; s0 = n_dash;
    hold(0, 4);
    key_n = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_code", code, 0);
    chk("clr_count", symbol_count, 0);
    chk("clr_busy", busy, 0);
    hold(1, 40);
    chk("clr_pulses", (n_dot - d0) + (n_dash - s0), 0);

    // enable dropped mid-press
    d0 = n_dot; s0 = n_dash; v0 = n_valid;
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("en_busy_before", busy, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_busy_after", busy, 0);
    @(negedge clk);
    enable = 1'b1;
    hold(0, 5); hold(1, 40);
    chk("en_pulses", (n_dot - d0) + (n_dash - s0) + (n_valid - v0), 0);

    // reset during GAP
    hold(0, 4); hold(1, 10);
    chk("rst_gap_busy", busy, 1);
    chk("rst_gap_count", symbol_count, 1);
    v0 = n_valid;
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_code", code, 0);
    chk("rst_count", symbol_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold(1, 40);
    chk("rst_no_valid", n_valid - v0, 0);

    // Gap race: released width GAP puts the press edge on the timeout cycle
    hold(0, 4); hold(1, 40);
    v0 = n_valid;
    hold(0, 4); hold(1, GAP); hold(0, 4);
    chk("race_no_valid", n_valid - v0, 0);
    chk("race_busy", busy, 1);
    hold(1, 40);
    chk("race_valid", n_valid - v0, 1);
    chk("race_count", v_cnt, 2);
    chk("race_code", v_code, 10'b1010000000);

    // Randomised keying with occasional bounce, clear and enable drops
    seg_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg_left == 0) begin
        key_n = ~key_n;
        if ($urandom_range(0, 7) == 0) seg_left = $urandom_range(1, 2);
        else if (key_n) seg_left = $urandom_range(3, 45);
        else seg_left = $urandom_range(3, 16);
      end
      seg_left--;
      clear = ($urandom_range(0, 149) == 0);
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 29) == 0) enable = 1'b1;
      @(negedge clk);
    end
    clear = 1'b0;
    enable = 1'b1;
    hold(1, 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
